// File: rtl/mips_pkg.sv
// Shared fetch-stage types and MIPS opcode/function constants.
package mips_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        KILL = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    localparam logic [5:0] OP_J   = 6'h02;
    localparam logic [5:0] OP_JAL = 6'h03;
    localparam logic [5:0] OP_BEQ = 6'h04;
    localparam logic [5:0] OP_BNE = 6'h05;
    localparam logic [5:0] FN_JR  = 6'h08;

    localparam int unsigned IM_DEPTH_DEF = 256;
    localparam int unsigned IM_AW        = $clog2(IM_DEPTH_DEF);

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: halt, jr, jump, taken branch, sequential; all targets wrap mod IM_DEPTH.
module pc_next_sel
    import mips_pkg::*;
#(
    parameter int unsigned IM_DEPTH = 256
) (
    input  logic        active,
    input  logic        halt_req,
    input  logic        jr,
    input  logic [31:0] jr_tgt,
    input  logic        jump,
    input  logic [25:0] jump_tgt,
    input  logic        branch_taken,
    input  logic [31:0] branch_off,
    input  logic [31:0] addr,
    input  logic [31:0] instr_pc,
    output logic [31:0] next_addr,
    output logic [31:0] addr_plus1,
    output logic        redirect,
    output logic        go_halt
);

    localparam logic [31:0] MASK = 32'(IM_DEPTH - 1);

    logic [31:0] raw;

    assign addr_plus1 = (addr + 32'd1) & MASK;

    // Redirects are only honoured when the instruction on IM output is on the correct path.
    always_comb begin
        raw      = addr + 32'd1;
        redirect = 1'b0;
        go_halt  = 1'b0;
        if (halt_req) begin
            go_halt = 1'b1;
            raw     = addr;
        end else if (active && jr) begin
            redirect = 1'b1;
            raw      = jr_tgt;
        end else if (active && jump) begin
            redirect = 1'b1;
            raw      = {addr[31:26], jump_tgt};
        end else if (active && branch_taken) begin
            redirect = 1'b1;
            raw      = instr_pc + 32'd1 + branch_off;
        end
        next_addr = raw & MASK;
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC/fetch-control stage: drives IM word address and tags the IM output with its PC and valid bit.
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int unsigned IM_DEPTH   = 256,
    parameter bit          DELAY_SLOT = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_off,
    input  logic        jump,
    input  logic [25:0] jump_tgt,
    input  logic        jr,
    input  logic [31:0] jr_tgt,
    input  logic        halt_req,
    output logic [31:0] addr,
    output logic [31:0] instr_pc,
    output logic [31:0] pc_plus1,
    output logic        fetch_valid,
    output logic        halted,
    output logic [31:0] fetch_count
);

    fetch_state_t state, state_n;
    logic [31:0]  next_addr;
    logic [31:0]  addr_plus1;
    logic         redirect;
    logic         go_halt;

    assign fetch_valid = (state == RUN);
    assign halted      = (state == HALT);

    pc_next_sel #(
        .IM_DEPTH(IM_DEPTH)
    ) u_next_sel (
        .active       (fetch_valid),
        .halt_req     (halt_req),
        .jr           (jr),
        .jr_tgt       (jr_tgt),
        .jump         (jump),
        .jump_tgt     (jump_tgt),
        .branch_taken (branch_taken),
        .branch_off   (branch_off),
        .addr         (addr),
        .instr_pc     (instr_pc),
        .next_addr    (next_addr),
        .addr_plus1   (addr_plus1),
        .redirect     (redirect),
        .go_halt      (go_halt)
    );

    always_comb begin
        state_n = state;
        case (state)
            RUN, KILL: begin
                if (go_halt)
                    state_n = HALT;
                else if (redirect && !DELAY_SLOT)
                    state_n = KILL;
                else
                    state_n = RUN;
            end
            HALT:    state_n = HALT;
            default: state_n = KILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= KILL;
            addr        <= RESET_PC;
            instr_pc    <= '0;
            pc_plus1    <= 32'd1;
            fetch_count <= '0;
        end else if (!stall && state != HALT) begin
            state    <= state_n;
            addr     <= next_addr;
            instr_pc <= addr;
            pc_plus1 <= addr_plus1;
            if (fetch_valid)
                fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule
